// File: rtl/icache_rv32_pkg.sv
// Shared types and constants for the direct-mapped RV32 instruction cache.
package icache_rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ICACHE_IDLE   = 2'd0,
    ICACHE_FILL   = 2'd1,
    ICACHE_COMMIT = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_rv32_tag_ram.sv
// Per-line tag and valid storage: async read by index, sync write, flush-all.
// Only the valid bits are reset; the tag array is left uninitialised.
module icache_tag_ram_rv32 #(
  parameter int NUM_LINES = 64,
  parameter int TAG_W     = 22,
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic             o_rd_valid,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_wr_valid,
  input  logic             i_flush
);

  logic [TAG_W-1:0]     r_tag [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;

  always_ff @(posedge iCLK) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  // Flush has priority over a simultaneous valid write.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= i_wr_valid;
    end
  end

  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];

endmodule

// File: rtl/icache_rv32.sv
// Direct-mapped read-only instruction cache with zero-latency hits and
// whole-line refill over a valid-beat memory handshake.
module icache_rv32
  import icache_rv32_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [XLEN-1:0] iPCADDR,
  output logic [XLEN-1:0] oINSTR,
  output logic            oStallI,
  input  logic            iFLUSH,
  output logic            oMemREQ,
  output logic [XLEN-1:0] oMemADDR,
  input  logic            iMemVALID,
  input  logic [XLEN-1:0] iMemDATA
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = XLEN - OFF_W - IDX_W;
  localparam int LINE_W = XLEN - OFF_W;

  icache_state_e     r_state;
  logic [LINE_W-1:0] r_line;
  logic [WORD_W-1:0] r_beat;
  logic              r_memreq;
  logic [XLEN-1:0]   r_memaddr;
  logic              r_discard;

  logic [XLEN-1:0]   r_data [NUM_LINES*LINE_WORDS];

  logic [WORD_W-1:0] w_pc_word;
  logic [IDX_W-1:0]  w_pc_idx;
  logic [TAG_W-1:0]  w_pc_tag;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_rd_tag;
  logic              w_rd_valid;
  logic              w_hit;
  logic              w_fill_we;
  logic              w_tag_we;
  logic              w_last_beat;
  logic [WORD_W-1:0] w_next_beat;
  logic              w_unused;

  assign w_pc_word   = iPCADDR[OFF_W-1:2];
  assign w_pc_idx    = iPCADDR[OFF_W+IDX_W-1:OFF_W];
  assign w_pc_tag    = iPCADDR[XLEN-1:OFF_W+IDX_W];
  assign w_fill_idx  = r_line[IDX_W-1:0];
  assign w_unused    = &{1'b0, iPCADDR[1:0]};

  assign w_hit       = (r_state == ICACHE_IDLE) && w_rd_valid && (w_rd_tag == w_pc_tag);
  assign w_fill_we   = (r_state == ICACHE_FILL) && iMemVALID;
  assign w_tag_we    = (r_state == ICACHE_COMMIT);
  assign w_last_beat = (r_beat == WORD_W'(LINE_WORDS - 1));
  assign w_next_beat = r_beat + WORD_W'(1);

  icache_tag_ram_rv32 #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_tag_ram (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .i_rd_idx   (w_pc_idx),
    .o_rd_tag   (w_rd_tag),
    .o_rd_valid (w_rd_valid),
    .i_wr_en    (w_tag_we),
    .i_wr_idx   (w_fill_idx),
    .i_wr_tag   (r_line[LINE_W-1:IDX_W]),
    .i_wr_valid (!r_discard),
    .i_flush    (iFLUSH)
  );

  // Data array is not reset; it is only read once the matching valid bit is set.
  always_ff @(posedge iCLK) begin
    if (w_fill_we) begin
      r_data[{w_fill_idx, r_beat}] <= iMemDATA;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state   <= ICACHE_IDLE;
      r_line    <= '0;
      r_beat    <= '0;
      r_memreq  <= 1'b0;
      r_memaddr <= '0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        ICACHE_IDLE: begin
          if (!w_hit) begin
            r_line    <= iPCADDR[XLEN-1:OFF_W];
            r_beat    <= '0;
            r_memreq  <= 1'b1;
            r_memaddr <= {iPCADDR[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            r_state   <= ICACHE_FILL;
          end
        end
        ICACHE_FILL: begin
          // A flush during the burst lets it finish but keeps the line invalid.
          if (iFLUSH) begin
            r_discard <= 1'b1;
          end
          if (iMemVALID) begin
            r_beat    <= w_next_beat;
            r_memaddr <= {r_line, w_next_beat, 2'b00};
            if (w_last_beat) begin
              r_memreq <= 1'b0;
              r_state  <= ICACHE_COMMIT;
            end
          end
        end
        ICACHE_COMMIT: begin
          r_discard <= 1'b0;
          r_state   <= ICACHE_IDLE;
        end
        default: begin
          r_state <= ICACHE_IDLE;
        end
      endcase
    end
  end

  assign oINSTR   = r_data[{w_pc_idx, w_pc_word}];
  assign oStallI  = !w_hit;
  assign oMemREQ  = r_memreq;
  assign oMemADDR = r_memaddr;

endmodule

// File: tb/tb_icache_rv32.sv
// Randomized self-checking bench for icache_rv32 against a line-level cache model.
module tb_icache_rv32;

  localparam int LW = 4;
  localparam int NL = 64;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [31:0] iPCADDR = 32'h100;
  logic [31:0] oINSTR;
  logic        oStallI;
  logic        iFLUSH = 1'b0;
  logic        oMemREQ;
  logic [31:0] oMemADDR;
  logic        iMemVALID = 1'b0;
  logic [31:0] iMemDATA = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  bit          m_valid [NL];
  logic [31:0] m_tag   [NL];
  logic [31:0] last_addr = 32'h0;

  icache_rv32 #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iPCADDR   (iPCADDR),
    .oINSTR    (oINSTR),
    .oStallI   (oStallI),
    .iFLUSH    (iFLUSH),
    .oMemREQ   (oMemREQ),
    .oMemADDR  (oMemADDR),
    .iMemVALID (iMemVALID),
    .iMemDATA  (iMemDATA)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
    return (a * 32'h9E3779B1) ^ 32'h5EED1234;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endfunction

  // Called at a negedge; returns at the negedge where the fetch is served.
  // vmode: 0 valid always, 1 random valid, 2 fixed pattern 1,0,0,1,1,0,1.
  // fmode: 0 none, 1 flush in FILL at beat fbeat, 2 flush in COMMIT.
  task automatic do_fetch(input logic [31:0] addr, input int vmode, input int fmode, input int fbeat);
    logic [31:0] wa, base, tg;
    logic [6:0]  pat;
    int idx, cyc, beats, waits, nreq, refills;
    bit hit, v, fdone;
    pat   = 7'b1011001;
    wa    = addr & ~32'h3;
    base  = wa & ~(32'(4*LW) - 32'd1);
    idx   = int'((wa / (4*LW)) % NL);
    tg    = wa / (4*LW*NL);
    hit   = m_valid[idx] && (m_tag[idx] == tg);
    last_addr = addr;
    iPCADDR   = addr;
    iMemVALID = 1'b0;
    iFLUSH    = 1'b0;
    #1;
    chk("stall_now", 32'(oStallI), 32'(!hit));
    if (hit) begin
      chk("hit_instr", oINSTR, mem_word(wa));
      chk("hit_noreq", 32'(oMemREQ), 32'd0);
      $display("fetch %h hit instr=%h", addr, oINSTR);
      return;
    end
    cyc = 0; beats = 0; waits = 0; nreq = 0; fdone = 1'b0;
    while (1) begin
      @(negedge iCLK);
      cyc++;
      iFLUSH = 1'b0;
      if (cyc > 100) begin
        chk("refill_timeout", 32'd1, 32'd0);
        break;
      end
      if (!oStallI) break;
      if (oMemREQ) begin
        chk("memaddr", oMemADDR, base + 32'(4*(beats % LW)));
        if (vmode == 0) v = 1'b1;
        else if (vmode == 1) v = 1'($urandom % 2);
        else v = (nreq < 7) ? pat[nreq] : 1'b1;
        nreq++;
        if (fmode == 1 && !fdone && beats == fbeat) begin
          iFLUSH = 1'b1;
          fdone  = 1'b1;
        end
        iMemVALID = v;
        iMemDATA  = v ? mem_word(base + 32'(4*(beats % LW))) : $urandom;
        if (v) beats++; else waits++;
      end else begin
        if (fmode == 2 && !fdone && beats == LW) begin
          iFLUSH = 1'b1;
          fdone  = 1'b1;
        end
        // Junk beats outside FILL must be ignored.
        iMemVALID = 1'($urandom % 2);
        iMemDATA  = $urandom;
      end
    end
    iMemVALID = 1'b0;
    iFLUSH    = 1'b0;
    refills = fdone ? 2 : 1;
    chk("beats", 32'(beats), 32'(LW*refills));
    chk("latency", 32'(cyc), 32'(refills*(LW+2) + waits));
    chk("miss_instr", oINSTR, mem_word(wa));
    chk("req_off", 32'(oMemREQ), 32'd0);
    if (fdone) model_flush();
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    $display("fetch %h miss refills=%0d waits=%0d cycles=%0d instr=%h", addr, refills, waits, cyc, oINSTR);
  endtask

  // Flush while the current address hits; the next cycle misses on it.
  task automatic do_flush();
    iFLUSH = 1'b1;
    @(negedge iCLK);
    iFLUSH = 1'b0;
    model_flush();
    #1;
    chk("flush_stall", 32'(oStallI), 32'd1);
    $display("flush at %h stall=%0d", last_addr, oStallI);
  endtask

  task automatic reset_mid_fill();
    logic [31:0] base;
    base = last_addr & ~(32'(4*LW) - 32'd1);
    @(negedge iCLK);
    chk("rst_pre_req", 32'(oMemREQ), 32'd1);
    iMemVALID = 1'b1;
    iMemDATA  = mem_word(base);
    @(negedge iCLK);
    iMemVALID = 1'b0;
    chk("rst_pre_addr", oMemADDR, base + 32'd4);
    #2 iRST = 1'b0;
    #1;
    chk("rst_async_req", 32'(oMemREQ), 32'd0);
    chk("rst_async_addr", oMemADDR, 32'd0);
    chk("rst_async_stall", 32'(oStallI), 32'd1);
    @(negedge iCLK);
    iRST = 1'b1;
    model_flush();
    $display("reset mid-fill at %h", last_addr);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    model_flush();
    #1;
    chk("reset_stall", 32'(oStallI), 32'd1);
    chk("reset_req", 32'(oMemREQ), 32'd0);
    chk("reset_addr", oMemADDR, 32'd0);
    repeat (3) @(negedge iCLK);
    iRST = 1'b1;

    do_fetch(32'h100, 0, 0, 0);
    do_fetch(32'h108, 0, 0, 0);
    do_fetch(32'h500, 0, 0, 0);
    do_fetch(32'h100, 0, 0, 0);
    do_fetch(32'h10E, 0, 0, 0);
    do_fetch(32'h2040, 2, 0, 0);
    do_fetch(32'h204C, 0, 0, 0);
    do_fetch(32'h3000, 0, 1, 2);
    do_fetch(32'h3004, 0, 0, 0);
    do_fetch(32'h3400, 1, 2, 0);
    do_flush();
    do_fetch(last_addr, 0, 0, 0);
    do_flush();
    reset_mid_fill();
    do_fetch(last_addr, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom % 20);
      if (r == 0) begin
        do_flush();
        do_fetch(last_addr, 1, 0, 0);
      end else begin
        a = 32'($urandom_range(0, 16383));
        if (r == 1) do_fetch(a, int'($urandom % 2), 1, int'($urandom % LW));
        else if (r == 2) do_fetch(a, int'($urandom % 2), 2, 0);
        else do_fetch(a, int'($urandom % 2), 0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
